// File: rtl/wb_sdram_initiator_pkg.sv
// Shared encodings for the Wishbone initiator: cycle-type constants, burst type
// and the FSM state set.
package wb_init_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        BUS   = 2'd2
    } state_e;

    // Cycle type for a beat: classic for single transfers, end-of-burst on the final beat.
    function automatic logic [2:0] beat_cti(input logic is_burst, input logic is_last);
        if (!is_burst) begin
            return CTI_CLASSIC;
        end
        if (is_last) begin
            return CTI_EOB;
        end
        return CTI_INCR;
    endfunction

endpackage

// File: rtl/wb_sdram_initiator_if.sv
// Request/response stream plus Wishbone master pins of the SDRAM initiator.
// The master modport is the initiator's view; slave is host + controller side.
interface wb_sdram_initiator_if #(
    parameter int AW   = 32,
    parameter int DW   = 32,
    parameter int BL_W = 4
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [AW-1:0]     req_addr;
    logic [DW/8-1:0]   req_sel;
    logic [BL_W-1:0]   req_len;

    logic              wd_valid;
    logic              wd_ready;
    logic [DW-1:0]     wd_data;

    logic              rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_last;
    logic              rsp_err;

    logic              wb_cyc_o;
    logic              wb_stb_o;
    logic              wb_we_o;
    logic [AW-1:0]     wb_adr_o;
    logic [DW-1:0]     wb_dat_o;
    logic [DW/8-1:0]   wb_sel_o;
    logic [2:0]        wb_cti_o;
    logic [1:0]        wb_bte_o;
    logic              wb_ack_i;
    logic [DW-1:0]     wb_dat_i;

    modport master (
        input  req_valid, req_we, req_addr, req_sel, req_len,
        output req_ready,
        input  wd_valid, wd_data,
        output wd_ready,
        output rsp_valid, rsp_rdata, rsp_last, rsp_err,
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o, wb_cti_o, wb_bte_o,
        input  wb_ack_i, wb_dat_i
    );

    modport slave (
        output req_valid, req_we, req_addr, req_sel, req_len,
        input  req_ready,
        output wd_valid, wd_data,
        input  wd_ready,
        input  rsp_valid, rsp_rdata, rsp_last, rsp_err,
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o, wb_cti_o, wb_bte_o,
        output wb_ack_i, wb_dat_i
    );

endinterface

// File: rtl/wb_sdram_initiator_addr_gen.sv
// Burst address/beat tracker: registered Wishbone address and CTI for the current
// beat, plus a last-beat flag derived from the beat counter.
module wb_init_addr_gen
    import wb_init_pkg::*;
#(
    parameter int AW   = 32,
    parameter int DW   = 32,
    parameter int BL_W = 4
) (
    input  logic            clk,
    input  logic            srst,
    input  logic            load_i,
    input  logic [AW-1:0]   load_addr_i,
    input  logic [BL_W-1:0] load_len_i,
    input  logic            step_i,
    output logic [AW-1:0]   adr_o,
    output logic [2:0]      cti_o,
    output logic            last_o
);

    localparam logic [AW-1:0] STEP = AW'(DW / 8);

    logic [AW-1:0]   adr_q, adr_d;
    logic [BL_W-1:0] beat_q, beat_d;
    logic [BL_W-1:0] len_q, len_d;
    logic [2:0]      cti_q, cti_d;

    always_comb begin
        adr_d  = adr_q;
        beat_d = beat_q;
        len_d  = len_q;
        cti_d  = cti_q;
        if (load_i) begin
            adr_d  = load_addr_i;
            beat_d = '0;
            len_d  = load_len_i;
            cti_d  = beat_cti(load_len_i != '0, load_len_i == '0);
        end else if (step_i) begin
            // Address wraps naturally modulo 2**AW; CTI looks ahead to the new beat.
            adr_d  = adr_q + STEP;
            beat_d = beat_q + 1'b1;
            cti_d  = beat_cti(1'b1, beat_d == len_q);
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            adr_q  <= '0;
            beat_q <= '0;
            len_q  <= '0;
            cti_q  <= CTI_CLASSIC;
        end else begin
            adr_q  <= adr_d;
            beat_q <= beat_d;
            len_q  <= len_d;
            cti_q  <= cti_d;
        end
    end

    assign adr_o  = adr_q;
    assign cti_o  = cti_q;
    assign last_o = (beat_q == len_q);

endmodule

// File: rtl/wb_sdram_initiator.sv
// Wishbone B3 initiator turning single/incrementing-burst stream requests into bus cycles.
// Optional ack timeout: define WB_INITIATOR_TIMEOUT_EN.
module wb_sdram_initiator
    import wb_init_pkg::*;
#(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int BL_W      = 4,
    parameter int TO_CYCLES = 1024
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    wb_sdram_initiator_if.master  bus
);

    if (((DW % 8) != 0) || (TO_CYCLES < 1)) begin : g_param_check
        $error("wb_sdram_initiator: DW must be a multiple of 8 and TO_CYCLES >= 1");
    end

    state_e          state_q, state_d;
    logic            req_ready_q, req_ready_d;
    logic            wd_ready_q, wd_ready_d;
    logic            cyc_q, cyc_d;
    logic            stb_q, stb_d;
    logic            we_q, we_d;
    logic [DW/8-1:0] sel_q, sel_d;
    logic [DW-1:0]   dat_q, dat_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic            rsp_last_q, rsp_last_d;

    logic            accept;
    logic            step;
    logic            last_beat;
    logic            timeout;
    logic [AW-1:0]   adr;
    logic [2:0]      cti;

    wb_init_addr_gen #(
        .AW   (AW),
        .DW   (DW),
        .BL_W (BL_W)
    ) u_addr_gen (
        .clk         (wb_clk_i),
        .srst        (wb_rst_i),
        .load_i      (accept),
        .load_addr_i (bus.req_addr),
        .load_len_i  (bus.req_len),
        .step_i      (step),
        .adr_o       (adr),
        .cti_o       (cti),
        .last_o      (last_beat)
    );

`ifdef WB_INITIATOR_TIMEOUT_EN
    localparam int TO_W = $clog2(TO_CYCLES + 1);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            rsp_err_q;

    // Counts stalled strobe cycles; the TO_CYCLES-th stall aborts the transfer.
    assign timeout  = (state_q == BUS) && stb_q && !bus.wb_ack_i
                      && (to_cnt_q == TO_W'(TO_CYCLES - 1));
    assign to_cnt_d = ((state_q == BUS) && !bus.wb_ack_i && !timeout) ? to_cnt_q + 1'b1 : '0;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            to_cnt_q  <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            to_cnt_q  <= to_cnt_d;
            rsp_err_q <= timeout;
        end
    end

    assign bus.rsp_err = rsp_err_q;
`else
    assign timeout     = 1'b0;
    assign bus.rsp_err = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        step        = 1'b0;
        we_d        = we_q;
        sel_d       = sel_q;
        dat_d       = dat_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_last_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    accept  = 1'b1;
                    we_d    = bus.req_we;
                    sel_d   = bus.req_sel;
                    state_d = bus.req_we ? FETCH : BUS;
                end
            end
            FETCH: begin
                if (bus.wd_valid && wd_ready_q) begin
                    dat_d   = bus.wd_data;
                    state_d = BUS;
                end
            end
            BUS: begin
                if (stb_q && bus.wb_ack_i) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = we_q ? '0 : bus.wb_dat_i;
                    rsp_last_d  = last_beat;
                    if (last_beat) begin
                        state_d = IDLE;
                    end else begin
                        step    = 1'b1;
                        state_d = we_q ? FETCH : BUS;
                    end
                end else if (timeout) begin
                    rsp_valid_d = 1'b1;
                    rsp_last_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Bus and handshake outputs follow the next state so they are registered.
        req_ready_d = (state_d == IDLE);
        wd_ready_d  = (state_d == FETCH);
        cyc_d       = (state_d != IDLE);
        stb_d       = (state_d == BUS);
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b0;
            wd_ready_q  <= 1'b0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            dat_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            wd_ready_q  <= wd_ready_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            dat_q       <= dat_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_last_q  <= rsp_last_d;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.wd_ready  = wd_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_last  = rsp_last_q;
    assign bus.wb_cyc_o  = cyc_q;
    assign bus.wb_stb_o  = stb_q;
    assign bus.wb_we_o   = we_q;
    assign bus.wb_adr_o  = adr;
    assign bus.wb_dat_o  = dat_q;
    assign bus.wb_sel_o  = sel_q;
    assign bus.wb_cti_o  = cti;
    assign bus.wb_bte_o  = BTE_LINEAR;

endmodule

// File: tb/tb_wb_sdram_initiator.sv
// Randomized self-checking bench: the bench plays host and Wishbone slave and checks
// every cycle against expected addresses/CTI/responses computed per beat.
module tb_wb_sdram_initiator;

    localparam int AW        = 32;
    localparam int DW        = 32;
    localparam int BL_W      = 4;
    localparam int TO_CYCLES = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors     = 0;
    int   miscompares = 0;
    int   xfer_no     = 0;

    wb_sdram_initiator_if #(.AW(AW), .DW(DW), .BL_W(BL_W)) bus ();

    wb_sdram_initiator #(
        .AW        (AW),
        .DW        (DW),
        .BL_W      (BL_W),
        .TO_CYCLES (TO_CYCLES)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #(3_000_000);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: beat k of a burst sits at base + 4k (mod 2**32).
    function automatic logic [31:0] exp_adr(input logic [31:0] base, input int beat);
        return base + 32'(beat * (DW / 8));
    endfunction

    function automatic logic [31:0] exp_cti(input int len, input int beat);
        if (len == 0)    return 32'h0;
        if (beat == len) return 32'h7;
        return 32'h2;
    endfunction

    task automatic check_all_zero(input string tag);
        check_val({tag, "_cyc"},   32'(bus.wb_cyc_o), 0);
        check_val({tag, "_stb"},   32'(bus.wb_stb_o), 0);
        check_val({tag, "_we"},    32'(bus.wb_we_o), 0);
        check_val({tag, "_adr"},   bus.wb_adr_o, 0);
        check_val({tag, "_dat"},   bus.wb_dat_o, 0);
        check_val({tag, "_sel"},   32'(bus.wb_sel_o), 0);
        check_val({tag, "_cti"},   32'(bus.wb_cti_o), 0);
        check_val({tag, "_rdy"},   32'(bus.req_ready), 0);
        check_val({tag, "_wdrdy"}, 32'(bus.wd_ready), 0);
        check_val({tag, "_rsp"},   32'(bus.rsp_valid), 0);
        check_val({tag, "_rlast"}, 32'(bus.rsp_last), 0);
        check_val({tag, "_rerr"},  32'(bus.rsp_err), 0);
        check_val({tag, "_rdata"}, bus.rsp_rdata, 0);
    endtask

    // Offers the request, waits for acceptance; returns at the first negedge of the cycle.
    task automatic offer_req(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                             input int len, input bit hold);
        int n;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_sel   = sel;
        bus.req_len   = BL_W'(len);
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_val("req_ready_wait", 32'(bus.req_ready), 1);
        @(negedge clk);
        if (!hold) bus.req_valid = 1'b0;
        check_val("cyc_after_accept", 32'(bus.wb_cyc_o), 1);
        check_val("rsp_after_accept", 32'(bus.rsp_valid), 0);
    endtask

    task automatic do_xfer(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                           input int len, input int ack_wait, input int wd_wait,
                           input bit fixed_rd, input logic [31:0] rd_val, input bit hold);
        logic [31:0] wdat;
        logic [31:0] rdat;
        int          aw;
        int          ww;
        bit          just_acked;
        xfer_no++;
        $display("xfer %0d: %s addr=%08h sel=%h len=%0d hold=%0b",
                 xfer_no, we ? "WR" : "RD", addr, sel, len, hold);
        offer_req(we, addr, sel, len, hold);
        just_acked = 1'b1;
        for (int b = 0; b <= len; b++) begin
            aw   = (ack_wait < 0) ? int'($urandom_range(0, 3)) : ack_wait;
            ww   = (wd_wait < 0) ? int'($urandom_range(0, 3)) : wd_wait;
            wdat = $urandom;
            rdat = fixed_rd ? rd_val : $urandom;
            if (we) begin
                // Data phase: stb low, cyc high; stray acks here must be ignored.
                for (int i = 0; i <= ww; i++) begin
                    check_val("fetch_cyc",   32'(bus.wb_cyc_o), 1);
                    check_val("fetch_stb",   32'(bus.wb_stb_o), 0);
                    check_val("fetch_wdrdy", 32'(bus.wd_ready), 1);
                    check_val("fetch_adr",   bus.wb_adr_o, exp_adr(addr, b));
                    check_val("busy_rdy",    32'(bus.req_ready), 0);
                    if (!just_acked) check_val("fetch_rsp", 32'(bus.rsp_valid), 0);
                    just_acked     = 1'b0;
                    bus.wb_ack_i   = 1'($urandom_range(0, 1));
                    bus.wb_dat_i   = $urandom;
                    if (i == ww) begin
                        bus.wd_valid = 1'b1;
                        bus.wd_data  = wdat;
                    end
                    @(negedge clk);
                end
                bus.wd_valid = 1'b0;
                bus.wb_ack_i = 1'b0;
            end
            for (int i = 0; i <= aw; i++) begin
                check_val("bus_cyc",   32'(bus.wb_cyc_o), 1);
                check_val("bus_stb",   32'(bus.wb_stb_o), 1);
                check_val("bus_we",    32'(bus.wb_we_o), 32'(we));
                check_val("bus_sel",   32'(bus.wb_sel_o), 32'(sel));
                check_val("bus_adr",   bus.wb_adr_o, exp_adr(addr, b));
                check_val("bus_cti",   32'(bus.wb_cti_o), exp_cti(len, b));
                check_val("bus_bte",   32'(bus.wb_bte_o), 0);
                check_val("busy_rdy",  32'(bus.req_ready), 0);
                check_val("bus_wdrdy", 32'(bus.wd_ready), 0);
                if (we) check_val("bus_dat_o", bus.wb_dat_o, wdat);
                if (!just_acked) check_val("bus_rsp", 32'(bus.rsp_valid), 0);
                just_acked = 1'b0;
                if (i == aw) begin
                    bus.wb_ack_i = 1'b1;
                    bus.wb_dat_i = rdat;
                end
                @(negedge clk);
            end
            bus.wb_ack_i = 1'b0;
            check_val("rsp_valid", 32'(bus.rsp_valid), 1);
            check_val("rsp_rdata", bus.rsp_rdata, we ? 32'h0 : rdat);
            check_val("rsp_last",  32'(bus.rsp_last), 32'(b == len));
            check_val("rsp_err",   32'(bus.rsp_err), 0);
            just_acked = 1'b1;
            if (b == len) begin
                check_val("end_cyc", 32'(bus.wb_cyc_o), 0);
                check_val("end_stb", 32'(bus.wb_stb_o), 0);
                check_val("end_rdy", 32'(bus.req_ready), 1);
            end
        end
    endtask

    initial begin
        logic        rw;
        logic [31:0] a;
        logic [3:0]  s;
        int          l;
        int          n;
        bit          h;

        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_sel   = '0;
        bus.req_len   = '0;
        bus.wd_valid  = 1'b0;
        bus.wd_data   = '0;
        bus.wb_ack_i  = 1'b0;
        bus.wb_dat_i  = '0;

        // Power-on reset: every output cleared, req_ready one cycle after release.
        repeat (3) begin
            @(negedge clk);
            check_all_zero("por");
        end
        rst = 1'b0;
        @(negedge clk);
        check_val("por_release_rdy", 32'(bus.req_ready), 1);
        check_val("por_release_cyc", 32'(bus.wb_cyc_o), 0);

        // Reset held 3 cycles in the middle of a read burst.
        $display("xfer 0: RD burst interrupted by reset");
        offer_req(1'b0, 32'h0000_0200, 4'hF, 3, 1'b0);
        check_val("mid_stb", 32'(bus.wb_stb_o), 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("mid_rst");
        repeat (2) begin
            @(negedge clk);
            check_val("mid_rst_rsp", 32'(bus.rsp_valid), 0);
            check_val("mid_rst_cyc", 32'(bus.wb_cyc_o), 0);
        end
        rst = 1'b0;
        @(negedge clk);
        check_val("mid_release_rdy", 32'(bus.req_ready), 1);
        check_val("mid_release_rsp", 32'(bus.rsp_valid), 0);

        // Directed cases.
        do_xfer(1'b0, 32'h0000_0100, 4'hF, 0, 2, 0, 1'b1, 32'hDEAD_BEEF, 1'b0);
        @(negedge clk);
        do_xfer(1'b0, 32'hFFFF_FFF8, 4'hF, 3, 0, 0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        do_xfer(1'b1, 32'h0000_0A00, 4'h3, 1, 1, 5, 1'b0, 32'h0, 1'b0);
        do_xfer(1'b0, 32'h0000_1000, 4'hC, 4, -1, -1, 1'b0, 32'h0, 1'b1);
        do_xfer(1'b1, 32'h0000_2000, 4'hF, 2, -1, -1, 1'b0, 32'h0, 1'b0);

`ifdef WB_INITIATOR_TIMEOUT_EN
        // No ack at all: strobe held for TO_CYCLES stalls, then an error response.
        $display("xfer T: RD with no ack, expect timeout");
        offer_req(1'b0, 32'h0000_0040, 4'hF, 2, 1'b0);
        n = 0;
        while (bus.wb_stb_o === 1'b1 && n < 100) begin
            check_val("to_rsp_quiet", 32'(bus.rsp_valid), 0);
            @(negedge clk);
            n++;
        end
        check_val("to_stall_cycles", 32'(n), 32'(TO_CYCLES));
        check_val("to_cyc",  32'(bus.wb_cyc_o), 0);
        check_val("to_rsp",  32'(bus.rsp_valid), 1);
        check_val("to_last", 32'(bus.rsp_last), 1);
        check_val("to_err",  32'(bus.rsp_err), 1);
        check_val("to_rdy",  32'(bus.req_ready), 1);
        @(negedge clk);
        check_val("to_rsp_pulse", 32'(bus.rsp_valid), 0);
        check_val("to_err_pulse", 32'(bus.rsp_err), 0);
`endif

        // Randomized traffic, including wrap near the top of the address space.
        for (int t = 0; t < 40; t++) begin
            rw = 1'($urandom_range(0, 1));
            a  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFC0 | ($urandom & 32'h3C))
                                             : ($urandom & 32'hFFFF_FFFC);
            s  = 4'($urandom_range(1, 15));
            l  = ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 5));
            h  = (t != 39) && ($urandom_range(0, 2) == 0);
            do_xfer(rw, a, s, l, -1, -1, 1'b0, 32'h0, h);
            if (!h) begin
                n = int'($urandom_range(0, 2));
                repeat (n) @(negedge clk);
            end
        end

        bus.req_valid = 1'b0;
        @(negedge clk);
        check_val("final_idle_cyc", 32'(bus.wb_cyc_o), 0);
        check_val("final_idle_rdy", 32'(bus.req_ready), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wb_sdram_initiator.md
Name: wb_sdram_initiator

Overview:
Synthesizable Wishbone B3 initiator that drives the SDRAM controller's Wishbone slave port from a simple request/response stream interface. It converts single or incrementing-burst read/write requests into Wishbone classic and registered-feedback cycles. It is the bus-driving counterpart to the whitebox protocol checkers and must satisfy reset rules 3.00/3.05/3.10 and cycle rules 3.25/3.35 by construction. It sits between the testbench or host logic and the controller's wb_* slave pins.

Parameters:
AW, 32, Wishbone byte-address width
DW, 32, Wishbone data width (multiple of 8)
BL_W, 4, burst-length field width; max burst = 2**BL_W beats
TO_CYCLES, 1024, ack timeout in wb_clk_i cycles (used only with the optional feature)

Ports:
wb_clk_i  in  1  sole clock
wb_rst_i  in  1  reset; synchronous, active-high
req_valid  in  1  request offered
req_ready  out  1  request accepted when high together with req_valid
req_we  in  1  1 = write, 0 = read
req_addr  in  AW  start byte address; DW/8-aligned
req_sel  in  DW/8  byte enables, applied to all beats
req_len  in  BL_W  beats minus 1
wd_valid  in  1  write data offered
wd_ready  out  1  write data taken
wd_data  in  DW  write beat data
rsp_valid  out  1  one-cycle pulse per completed beat
rsp_rdata  out  DW  read data; 0 for writes
rsp_last  out  1  final beat, or aborted transfer
rsp_err  out  1  transfer aborted by timeout
wb_cyc_o  out  1  Wishbone cycle
wb_stb_o  out  1  Wishbone strobe
wb_we_o  out  1  Wishbone write enable
wb_adr_o  out  AW  Wishbone address
wb_dat_o  out  DW  Wishbone write data
wb_sel_o  out  DW/8  Wishbone byte select
wb_cti_o  out  3  cycle type identifier
wb_bte_o  out  2  burst type extension; constant 2'b00 (linear)
wb_ack_i  in  1  Wishbone acknowledge
wb_dat_i  in  DW  Wishbone read data

Behaviour:
- Reset: on any edge with wb_rst_i=1, state goes to IDLE.
  - Outputs during reset: wb_cyc_o, wb_stb_o, wb_we_o, wd_ready, rsp_* = 0; wb_adr_o, wb_dat_o, wb_sel_o, wb_cti_o = 0; req_ready = 0.
  - req_ready = 1 from the first edge after reset deasserts.
  - A reset mid-burst drops cyc/stb at that edge; no rsp is emitted.
- All outputs are registered.
- States:
  - IDLE: req_ready = 1.
  - FETCH: cyc = 1, stb = 0, wd_ready = 1.
  - BUS: cyc = 1, stb = 1.
- Transitions:
  - IDLE → accept on req_valid & req_ready; latch we, addr, sel, len; clear beat counter.
  - IDLE → write goes to FETCH; read goes to BUS. cyc rises one cycle after acceptance.
  - FETCH → on wd_valid, capture wd_data into wb_dat_o, then go to BUS.
  - BUS → on wb_ack_i:
    - Pulse rsp_valid next cycle; rsp_rdata = registered wb_dat_i for reads, 0 for writes.
    - Last beat: drop cyc and stb together, assert rsp_last, return to IDLE.
    - Read, not last: stay in BUS with stb held high; wb_adr_o += DW/8 at the same edge.
    - Write, not last: go to FETCH with stb low and cyc held high; wb_adr_o += DW/8.
- wb_stb_o is never high while wb_cyc_o is low.
- wb_cyc_o is never high in IDLE.
- wb_ack_i is ignored unless stb is high.
- CTI encoding:
  - Single beat (len = 0): 3'b000.
  - Burst, non-final beats: 3'b010.
  - Burst, final beat: 3'b111.
- Address wraps modulo 2**AW; no boundary check.
- The bus signals wb_we_o and wb_sel_o stay constant for the whole cycle.
- One transfer outstanding at most; req_ready = 0 in all states except IDLE.
- The idle gap between cycles is at least 1 cycle; cyc is low for ≥1 clock between back-to-back requests.

Optional Feature:
- Macro: WB_INITIATOR_TIMEOUT_EN.
- Enabled:
  - A counter runs while in BUS without wb_ack_i and clears on each ack.
  - When the counter reaches TO_CYCLES, cyc/stb drop at the next edge and remaining beats are abandoned.
  - That edge emits rsp_valid = rsp_last = rsp_err = 1, then the block returns to IDLE.
- Disabled: no counter; the block waits for ack indefinitely; rsp_err is tied to 0.

Decomposition:
- Package wb_init_pkg:
  - CTI constants: CTI_CLASSIC = 3'b000, CTI_INCR = 3'b010, CTI_EOB = 3'b111.
  - BTE_LINEAR = 2'b00.
  - State enum {IDLE, FETCH, BUS}.
- One sub-module, wb_init_addr_gen: holds the address register, increment, beat counter, last-beat and CTI generation.
- The FSM and data path stay in the top module.

Test Plan:
- Reset held 3 cycles during a read burst → cyc/stb = 0 at the first reset edge; req_ready = 1 one cycle after release; no rsp pulse.
- Single read at 0x100, sel = 4'hF, ack after 2 waits, dat_i = 0xDEADBEEF → adr = 0x100, cti = 000; one rsp_valid with rdata = 0xDEADBEEF and rsp_last = 1; cyc low the next cycle.
- Read burst len = 3 at 0xFFFFFFF8, ack every cycle → adr sequence F8, FC, 00, 04; cti sequence 010, 010, 010, 111; 4 rsp pulses, last on the 4th.
- Write burst len = 1 with wd_valid delayed 5 cycles before beat 2 → stb low and cyc high during the gap; dat_o = beat 2 data; 2 rsp pulses with rdata = 0.
- With WB_INITIATOR_TIMEOUT_EN and TO_CYCLES = 16, no ack → cyc drops after 16 stalled cycles; one rsp with err = last = 1; the next request is accepted normally.
- req_valid held high during a busy burst → req_ready = 0 throughout; the second request is accepted the first cycle after return to IDLE.
